// File: rtl/mtcmos_sleep_ctrl.sv
// mtcmos_sleep_ctrl
// Sequences an MTCMOS-gated flip-flop bank into and out of sleep:
// drain pending updates, isolate outputs, assert the sleep switch, then on
// wake release the switch, wait for the rail, settle, and restore clocks.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   sleep_req  level request to enter sleep
//   wake_req   level request to exit sleep (wins over sleep_req)
//   dp_idle    gated bank has no pending update
//   pwr_good   virtual rail restored
//   sleep      sleep switch control (registered)
//   iso_en     output isolation clamp (registered)
//   clk_en     gated-domain clock enable (registered)
//   asleep     high only in ASLEEP (registered)
//   wake_err   sticky wake-timeout flag, cleared only by rst
//   state_o    current state encoding for debug
module mtcmos_sleep_ctrl #(
   parameter int unsigned ISO_DLY  = 2,
   parameter int unsigned SLP_DLY  = 4,
   parameter int unsigned WAKE_DLY = 8,
   parameter int unsigned WAKE_TMO = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sleep_req,
   input  logic       wake_req,
   input  logic       dp_idle,
   input  logic       pwr_good,
   output logic       sleep,
   output logic       iso_en,
   output logic       clk_en,
   output logic       asleep,
   output logic       wake_err,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      StActive  = 3'd0,
      StDrain   = 3'd1,
      StIsolate = 3'd2,
      StSleepOn = 3'd3,
      StAsleep  = 3'd4,
      StWake    = 3'd5,
      StSettle  = 3'd6,
      StRestore = 3'd7
   } state_e;

   // Counter preloads: a timed state lasts exactly its delay because the
   // exit happens in the cycle the counter reads zero.
   localparam logic [9:0] IsoLoad  = 10'(ISO_DLY - 1);
   localparam logic [9:0] SlpLoad  = 10'(SLP_DLY - 1);
   localparam logic [9:0] TmoLoad  = 10'(WAKE_TMO - 1);
   localparam logic [9:0] DlyLoad  = 10'(WAKE_DLY - 1);

   state_e     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic       wake_lat_q, wake_lat_d;
   logic       err_set;

   always_comb begin
      state_d = state_q;
      err_set = 1'b0;
      case (state_q)
         StActive:  if (sleep_req && !wake_req) state_d = StDrain;
         StDrain: begin
            if (wake_req || !sleep_req) state_d = StActive;
            else if (dp_idle)           state_d = StIsolate;
         end
         // wake_req deliberately ignored until the switch is on
         StIsolate: if (cnt_q == '0) state_d = StSleepOn;
         StSleepOn: begin
            if (cnt_q == '0) state_d = (wake_lat_q || wake_req) ? StWake : StAsleep;
         end
         StAsleep:  if (wake_req) state_d = StWake;
         StWake: begin
            if (pwr_good) begin
               state_d = StSettle;
            end else if (cnt_q == '0) begin
               state_d = StSettle;
               err_set = 1'b1;
            end
         end
         StSettle:  if (cnt_q == '0) state_d = StRestore;
         StRestore: state_d = StActive;
         default:   state_d = StActive;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         case (state_d)
            StIsolate: cnt_d = IsoLoad;
            StSleepOn: cnt_d = SlpLoad;
            StWake:    cnt_d = TmoLoad;
            StSettle:  cnt_d = DlyLoad;
            default:   cnt_d = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 10'd1;
      end
   end

   // Wake requests during the minimum sleep hold are remembered so the hold
   // is never cut short yet the request is not lost.
   always_comb begin
      wake_lat_d = 1'b0;
      if (state_q == StSleepOn && state_d == StSleepOn) wake_lat_d = wake_lat_q | wake_req;
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StActive;
         cnt_q      <= '0;
         wake_lat_q <= 1'b0;
         sleep      <= 1'b0;
         iso_en     <= 1'b0;
         clk_en     <= 1'b1;
         asleep     <= 1'b0;
         wake_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wake_lat_q <= wake_lat_d;
         sleep      <= (state_d == StSleepOn) || (state_d == StAsleep);
         iso_en     <= !((state_d == StActive) || (state_d == StDrain));
         clk_en     <= (state_d == StActive) || (state_d == StDrain) || (state_d == StRestore);
         asleep     <= (state_d == StAsleep);
         wake_err   <= wake_err | err_set;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_mtcmos_sleep_ctrl.sv
// tb_mtcmos_sleep_ctrl
// Self-checking bench for mtcmos_sleep_ctrl: a time-in-state reference model
// checked every cycle, invariant checks, directed scenarios with literal
// expectations, then randomized stimulus.
module tb_mtcmos_sleep_ctrl;

   localparam int ISO  = 2;
   localparam int SLP  = 4;
   localparam int WDLY = 8;
   localparam int WTMO = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sleep_req = 1'b0;
   logic       wake_req = 1'b0;
   logic       dp_idle = 1'b0;
   logic       pwr_good = 1'b0;
   logic       sleep, iso_en, clk_en, asleep, wake_err;
   logic [2:0] state_o;

   int tests = 0;
   int fails = 0;

   mtcmos_sleep_ctrl #(
      .ISO_DLY  (ISO),
      .SLP_DLY  (SLP),
      .WAKE_DLY (WDLY),
      .WAKE_TMO (WTMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sleep_req (sleep_req),
      .wake_req  (wake_req),
      .dp_idle   (dp_idle),
      .pwr_good  (pwr_good),
      .sleep     (sleep),
      .iso_en    (iso_en),
      .clk_en    (clk_en),
      .asleep    (asleep),
      .wake_err  (wake_err),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: state index plus cycles already spent in it.
   int m_state = 0;
   int m_time  = 0;
   bit m_lat   = 0;
   bit m_err   = 0;
   bit m_valid = 0;
   bit rst_edge = 0;
   bit p_sleep = 0, p_iso = 0, p_valid = 0;
   bit saw_asleep = 0;

   int exp_sleep [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
   int exp_iso   [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
   int exp_clk   [8] = '{1, 1, 0, 0, 0, 0, 0, 1};

   task automatic model_step();
      int t, nx;
      bit lat2;
      if (rst) begin
         m_state = 0; m_time = 0; m_lat = 0; m_err = 0; m_valid = 1;
         return;
      end
      t    = m_time + 1;
      nx   = m_state;
      lat2 = m_lat | wake_req;
      case (m_state)
         0: if (sleep_req && !wake_req) nx = 1;
         1: if (wake_req || !sleep_req) nx = 0; else if (dp_idle) nx = 2;
         2: if (t == ISO) nx = 3;
         3: if (t == SLP) nx = lat2 ? 5 : 4;
         4: if (wake_req) nx = 5;
         5: if (pwr_good) nx = 6; else if (t == WTMO) begin nx = 6; m_err = 1; end
         6: if (t == WDLY) nx = 7;
         default: nx = 0;
      endcase
      m_lat   = (m_state == 3 && nx == 3) ? lat2 : 1'b0;
      m_time  = (nx == m_state) ? t : 0;
      m_state = nx;
   endtask

   always @(posedge clk) begin
      rst_edge = rst;
      model_step();
      #1;
      if (m_valid) begin
         check("state", int'(state_o), m_state);
         check("sleep", int'(sleep), exp_sleep[m_state]);
         check("iso_en", int'(iso_en), exp_iso[m_state]);
         check("clk_en", int'(clk_en), exp_clk[m_state]);
         check("asleep", int'(asleep), int'(m_state == 4));
         check("wake_err", int'(wake_err), int'(m_err));
         check("inv_clk_and_sleep", int'(clk_en && sleep), 0);
         check("inv_iso_during_sleep", int'(sleep && !iso_en), 0);
         if (p_valid) begin
            check("inv_iso_before_sleep", int'(sleep && !p_sleep && !p_iso), 0);
            check("inv_iso_after_sleep", int'(p_sleep && !rst_edge && !iso_en), 0);
         end
      end
      p_sleep = sleep;
      p_iso   = iso_en;
      p_valid = m_valid;
      if (asleep) saw_asleep = 1;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_state(input int st, input int bound, input string nm);
      int n = 0;
      while (int'(state_o) != st && n < bound) begin
         tick();
         n++;
      end
      check(nm, int'(state_o), st);
   endtask

   // Counts cycles spent in st, starting in its first cycle.
   task automatic count_state(input int st, output int n);
      n = 0;
      while (int'(state_o) == st && n < 2000) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n, f_iso, f_sleep, f_asleep;
      bit bad;

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_state", int'(state_o), 0);
      check("reset_clk_en", int'(clk_en), 1);
      check("reset_iso_en", int'(iso_en), 0);
      check("reset_sleep", int'(sleep), 0);

      // Entry sequence timing
      sleep_req = 1'b1;
      dp_idle   = 1'b1;
      f_iso = 0; f_sleep = 0; f_asleep = 0; bad = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (iso_en && f_iso == 0) f_iso = i;
         if (sleep && f_sleep == 0) f_sleep = i;
         if (asleep && f_asleep == 0) f_asleep = i;
         if (i >= 2 && i <= 8 && clk_en) bad = 1;
      end
      check("entry_iso_edge", f_iso, 2);
      check("entry_sleep_edge", f_sleep, 4);
      check("entry_asleep_edge", f_asleep, 8);
      check("entry_clk_en_low", int'(bad), 0);

      // Normal wake, pwr_good three cycles after wake
      wake_req = 1'b1;
      tick();
      check("wake_entered", int'(state_o), 5);
      wake_req = 1'b0;
      tick();
      tick();
      pwr_good = 1'b1;
      tick();
      count_state(6, n);
      check("settle_cycles", n, 8);
      count_state(7, n);
      check("restore_cycles", n, 1);
      check("wake_back_active", int'(state_o), 0);
      check("wake_iso_off", int'(iso_en), 0);
      check("wake_no_err", int'(wake_err), 0);
      pwr_good = 1'b0;

      // Wake timeout
      wait_state(4, 50, "reach_asleep");
      wake_req = 1'b1;
      tick();
      wake_req  = 1'b0;
      sleep_req = 1'b0;
      count_state(5, n);
      check("wake_tmo_cycles", n, 64);
      check("wake_err_set", int'(wake_err), 1);
      wait_state(0, 50, "tmo_back_active");
      repeat (3) tick();
      check("wake_err_sticky", int'(wake_err), 1);

      // Drain held off by busy datapath, then request withdrawn
      sleep_req = 1'b1;
      dp_idle   = 1'b0;
      tick();
      bad = 0;
      repeat (20) begin
         tick();
         if (int'(state_o) != 1 || sleep || iso_en) bad = 1;
      end
      check("drain_hold", int'(bad), 0);
      sleep_req = 1'b0;
      tick();
      check("drain_abort", int'(state_o), 0);

      // Wake in the second SLEEP_ON cycle: full hold, then WAKE directly
      saw_asleep = 0;
      sleep_req  = 1'b1;
      dp_idle    = 1'b1;
      wait_state(3, 20, "reach_sleep_on");
      tick();
      wake_req = 1'b1;
      tick();
      wake_req = 1'b0;
      count_state(3, n);
      check("sleep_on_hold", n + 2, 4);
      check("latched_wake", int'(state_o), 5);
      check("never_asleep", int'(saw_asleep), 0);
      sleep_req = 1'b0;
      pwr_good  = 1'b1;
      wait_state(0, 30, "latched_back_active");
      pwr_good = 1'b0;

      // Reset in the second SLEEP_ON cycle
      sleep_req = 1'b1;
      wait_state(3, 20, "reach_sleep_on2");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sleep_req = 1'b0;
      check("rst_state", int'(state_o), 0);
      check("rst_sleep", int'(sleep), 0);
      check("rst_iso", int'(iso_en), 0);
      check("rst_clk_en", int'(clk_en), 1);
      check("rst_asleep", int'(asleep), 0);
      check("rst_wake_err", int'(wake_err), 0);

      // Randomized traffic; the per-cycle model check does the work
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         sleep_req = ($urandom_range(0, 3) != 0);
         wake_req  = ($urandom_range(0, 9) == 0);
         dp_idle   = ($urandom_range(0, 1) == 1);
         pwr_good  = ((i / 150) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
